// File: rtl/init_gen.sv
// Memory initialisation sequencer: writes an identity, constant or descending pattern to every table entry.
// Optional macro INIT_READBACK_EN adds a read-back verify pass with rddata input and sticky err output.
module init_gen #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] fill_val,
`ifdef INIT_READBACK_EN
   input  logic [DATA_W-1:0] rddata,
   output logic              err,
`endif
   output logic              rdy,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wrdata,
   output logic              wren,
   output logic              done
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0] ONE_IDX  = (ADDR_W+1)'(1);

`ifdef INIT_READBACK_EN
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SETUP      = 3'd1,
      WRITE      = 3'd2,
      CHECK      = 3'd3,
      CHECK_LAST = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WRITE = 2'd2
   } state_t;
`endif

   state_t            state_r, state_s;
   logic [ADDR_W:0]   idx_r, idx_s;
   logic [1:0]        mode_r, mode_s;
   logic [DATA_W-1:0] fill_r, fill_s;
   logic              rdy_r, rdy_s;
   logic              wren_r, wren_s;
   logic              done_r, done_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [DATA_W-1:0] wrdata_r, wrdata_s;
`ifdef INIT_READBACK_EN
   logic              err_r, err_s;
`endif

   // Pattern value for index i; the index is zero-extended or truncated to the data width.
   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                 input logic [DATA_W-1:0] fv,
                                                 input logic [ADDR_W:0] i);
      logic [ADDR_W:0]        v;
      logic [DATA_W+ADDR_W:0] wide;
      case (m)
         2'b10:   v = LAST_IDX - i;
         default: v = i;
      endcase
      wide = {{DATA_W{1'b0}}, v};
      if (m == 2'b01) begin
         return fv;
      end else begin
         return wide[DATA_W-1:0];
      end
   endfunction

   // Next-state, index, latched configuration and next registered output values.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      mode_s  = mode_r;
      fill_s  = fill_r;
`ifdef INIT_READBACK_EN
      err_s   = err_r;
`endif
      case (state_r)
         IDLE: begin
            if (en) begin
               state_s = SETUP;
               mode_s  = mode;
               fill_s  = fill_val;
`ifdef INIT_READBACK_EN
               err_s   = 1'b0;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         SETUP: begin
            state_s = WRITE;
            idx_s   = '0;
         end
         WRITE: begin
            if (idx_r == LAST_IDX) begin
`ifdef INIT_READBACK_EN
               state_s = CHECK;
`else
               state_s = IDLE;
`endif
               idx_s = '0;
            end else begin
               idx_s = idx_r + ONE_IDX;
            end
         end
`ifdef INIT_READBACK_EN
         // rddata lags addr by one cycle, so each edge verifies the previous index.
         CHECK: begin
            if ((idx_r != '0) && (rddata != pattern(mode_r, fill_r, idx_r - ONE_IDX))) begin
               err_s = 1'b1;
            end else begin
               err_s = err_r;
            end
            if (idx_r == LAST_IDX) begin
               state_s = CHECK_LAST;
            end else begin
               state_s = CHECK;
            end
            idx_s = idx_r + ONE_IDX;
         end
         CHECK_LAST: begin
            if (rddata != pattern(mode_r, fill_r, idx_r - ONE_IDX)) begin
               err_s = 1'b1;
            end else begin
               err_s = err_r;
            end
            state_s = IDLE;
            idx_s   = '0;
         end
`endif
         default: begin
            state_s = IDLE;
            idx_s   = '0;
         end
      endcase

      rdy_s    = (state_s == IDLE);
      wren_s   = (state_s == WRITE);
      done_s   = (state_s == IDLE) && (state_r != IDLE);
      addr_s   = '0;
      wrdata_s = '0;
      if (state_s == WRITE) begin
         addr_s   = idx_s[ADDR_W-1:0];
         wrdata_s = pattern(mode_s, fill_s, idx_s);
`ifdef INIT_READBACK_EN
      end else if (state_s == CHECK) begin
         addr_s   = idx_s[ADDR_W-1:0];
         wrdata_s = '0;
`endif
      end else begin
         addr_s   = '0;
         wrdata_s = '0;
      end
   end

   // State, index, configuration and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         idx_r    <= '0;
         mode_r   <= 2'b00;
         fill_r   <= '0;
         rdy_r    <= 1'b1;
         wren_r   <= 1'b0;
         done_r   <= 1'b0;
         addr_r   <= '0;
         wrdata_r <= '0;
`ifdef INIT_READBACK_EN
         err_r    <= 1'b0;
`endif
      end else begin
         state_r  <= state_s;
         idx_r    <= idx_s;
         mode_r   <= mode_s;
         fill_r   <= fill_s;
         rdy_r    <= rdy_s;
         wren_r   <= wren_s;
         done_r   <= done_s;
         addr_r   <= addr_s;
         wrdata_r <= wrdata_s;
`ifdef INIT_READBACK_EN
         err_r    <= err_s;
`endif
      end
   end

   assign rdy    = rdy_r;
   assign wren   = wren_r;
   assign done   = done_r;
   assign addr   = addr_r;
   assign wrdata = wrdata_r;
`ifdef INIT_READBACK_EN
   assign err    = err_r;
`endif

endmodule
